// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb -- direct-mapped, write-back, write-allocate data cache.
//
// Sits between the pipeline MEM stage and a 128-bit block-wide memory.
// Data is stored exactly as received; no byte swapping.
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   proc_reset  synchronous active-high reset
//   proc_read   load request            proc_write  store request
//   proc_addr   30-bit word address: [1:0] word, [INDEX_BITS+1:2] index, rest tag
//   proc_wdata  store data
//   proc_stall  request not complete this cycle (processor holds request)
//   proc_rdata  load data, valid on a read hit in IDLE, 0 otherwise
//   mem_read    block fill request      mem_write  block writeback request
//   mem_addr    28-bit block address
//   mem_wdata   writeback line, word w at [32w+31:32w]
//   mem_rdata   fill line, same layout
//   mem_ready   memory completes the current transaction this cycle
module dcache_dm_wb #(
    parameter int INDEX_BITS    = 3,
    parameter int WORD_SEL_BITS = 2   // fixed: 4 words per 128-bit line
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;
    localparam int WORDS = 1 << WORD_SEL_BITS;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]             state;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [WORDS-1:0][31:0] data_q [LINES];
    logic [27:0]            miss_addr_q;
    logic [27:0]            victim_addr_q;

    logic [WORD_SEL_BITS-1:0] word_sel;
    logic [INDEX_BITS-1:0]    idx;
    logic [TAG_W-1:0]         addr_tag;
    logic [INDEX_BITS-1:0]    miss_idx;
    logic [TAG_W-1:0]         miss_tag;
    logic [INDEX_BITS-1:0]    victim_idx;
    logic                     hit;
    logic                     req;

    assign word_sel   = proc_addr[WORD_SEL_BITS-1:0];
    assign idx        = proc_addr[INDEX_BITS+1:2];
    assign addr_tag   = proc_addr[29:INDEX_BITS+2];
    assign miss_idx   = miss_addr_q[INDEX_BITS-1:0];
    assign miss_tag   = miss_addr_q[27:INDEX_BITS];
    assign victim_idx = victim_addr_q[INDEX_BITS-1:0];

    assign hit = valid_q[idx] & (tag_q[idx] == addr_tag);
    assign req = proc_read | proc_write;

    // Reset masks the stall so the pipeline is not frozen while it is flushed.
    assign proc_stall = ~proc_reset & ((state != IDLE) | (req & ~hit));

    // A simultaneous read+write is a write, so no load data is returned.
    always_comb begin
        proc_rdata = '0;
        if (state == IDLE && proc_read && !proc_write && hit)
            proc_rdata = data_q[idx][word_sel];
    end

    always_comb begin
        mem_read  = (state == ALLOCATE);
        mem_write = (state == WRITEBACK);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WRITEBACK) begin
            // The victim line is untouched until the fill, so reading it
            // straight from the array keeps the writeback data stable.
            mem_addr  = victim_addr_q;
            mem_wdata = data_q[victim_idx];
        end else if (state == ALLOCATE) begin
            mem_addr  = miss_addr_q;
        end
    end

    // Control state, valid and dirty bits.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state   <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (proc_write) dirty_q[idx] <= 1'b1;
                        end else begin
                            miss_addr_q <= proc_addr[29:2];
                            if (valid_q[idx] & dirty_q[idx]) begin
                                victim_addr_q <= {tag_q[idx], idx};
                                state         <= WRITEBACK;
                            end else begin
                                state         <= ALLOCATE;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        valid_q[miss_idx] <= 1'b1;
                        dirty_q[miss_idx] <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag arrays: no reset. Updates are suppressed during reset so an
    // aborted fill never leaves a partial line behind.
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            if (state == IDLE && proc_write && hit) begin
                data_q[idx][word_sel] <= proc_wdata;
            end else if (state == ALLOCATE && mem_ready) begin
                data_q[miss_idx] <= mem_rdata;
                tag_q[miss_idx]  <= miss_tag;
            end
        end
    end

endmodule
